ifu_prefetch: RTL and testbench

Parametrised successor to the single-beat instruction fetch unit. It is an AXI4 read master that issues INCR bursts, and it fills a FIFO_DEPTH-entry prefetch buffer with {instruction, pc, fault} records. The buffer is drained by the IDU through a valid/ready handshake. The block sits between the PC-redirect source (EXU/branch unit) and the IDU, and supports redirect/flush with discard of in-flight beats and a halt on fetch faults.

---
 rtl/ifu_prefetch_if.sv | 40 ++++
 rtl/ifu_prefetch.sv | 158 +++++++++++++++
 tb/tb_ifu_prefetch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// Signal bundle between the prefetch unit, the PC-redirect source, the IDU and the AXI4 read slave.
// The master modport is the prefetch unit's view; slave is everything around it.
interface ifu_prefetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        input  redirect_valid, redirect_pc, inst_ready, arready,
               rvalid, rdata, rresp, rlast,
        output inst_valid, inst, inst_pc, inst_fault,
               arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_ready, arready,
               rvalid, rdata, rresp, rlast,
        input  inst_valid, inst, inst_pc, inst_fault,
               arvalid, araddr, arid, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: AXI4 INCR-burst read master filling a small {inst, pc, fault} buffer
// that the IDU drains over valid/ready; supports redirect/flush and halts after a faulting beat.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          BURST_LEN  = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter int          AXI_ID     = 0
) (
    input logic            clk,
    input logic            rst,
    ifu_prefetch_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             halt_q, halt_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [7:0]       beat_idx_q, beat_idx_d;
    logic             discard_q, discard_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [64:0]      fifo_q [FIFO_DEPTH];

    logic        push;
    logic        pop;
    logic        have_room;
    logic        beat_fault;
    logic [64:0] push_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign have_room  = count_q <= CNT_W'(FIFO_DEPTH - BURST_LEN);
    assign beat_fault = |bus.rresp;
    assign push_entry = {beat_fault, araddr_q + {22'd0, beat_idx_q, 2'b00}, bus.rdata};
    assign pop        = (count_q != '0) && bus.inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        halt_d     = halt_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        beat_idx_d = beat_idx_q;
        discard_d  = discard_q;
        push       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!halt_q && !bus.redirect_valid && have_room) begin
                    state_d   = ADDR;
                    araddr_d  = fetch_pc_q;
                    // Trim the first burst so it never crosses a BURST_LEN-word boundary.
                    arlen_d   = 8'(BURST_LEN - 1) - 8'((fetch_pc_q >> 2) & 32'(BURST_LEN - 1));
                    discard_d = 1'b0;
                end
            end
            ADDR: begin
                if (bus.redirect_valid) discard_d = 1'b1;
                if (bus.arready) begin
                    state_d    = (discard_q || bus.redirect_valid) ? DRAIN : DATA;
                    beat_idx_d = '0;
                end
            end
            DATA: begin
                if (bus.redirect_valid) begin
                    state_d = (bus.rvalid && bus.rlast) ? IDLE : DRAIN;
                end else if (bus.rvalid) begin
                    push       = 1'b1;
                    beat_idx_d = beat_idx_q + 8'd1;
                    if (bus.rlast) begin
                        fetch_pc_d = fetch_pc_q + {22'd0, arlen_q, 2'b00} + 32'd4;
                        state_d    = IDLE;
                    end
                    if (beat_fault) begin
                        halt_d = 1'b1;
                        if (!bus.rlast) state_d = DRAIN;
                    end
                end
            end
            default: begin
                if (bus.rvalid && bus.rlast) state_d = IDLE;
            end
        endcase

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            halt_d     = 1'b0;
        end
    end

    // A redirect flushes the buffer outright, so it wins over any same-cycle pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            halt_q     <= 1'b0;
            araddr_q   <= RESET_PC;
            arlen_q    <= '0;
            beat_idx_q <= '0;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            halt_q     <= halt_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            beat_idx_q <= beat_idx_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    assign bus.inst_valid = count_q != '0;
    assign {bus.inst_fault, bus.inst_pc, bus.inst} = fifo_q[rd_ptr_q];

    assign bus.arvalid = state_q == ADDR;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.arid    = 4'(AXI_ID);
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.rready  = (state_q == DATA) || (state_q == DRAIN);
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: the initial block plays AXI slave and IDU step by step and
// checks every observation against hand-computed addresses, lengths and buffer contents.
module tb_ifu_prefetch;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    ifu_prefetch_if bus ();

    ifu_prefetch #(
        .RESET_PC  (32'h8000_0000),
        .BURST_LEN (4),
        .FIFO_DEPTH(4),
        .AXI_ID    (0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // The slave returns a recognisable word per address so stale or shuffled entries show up.
    function automatic logic [31:0] data_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic fault);
        check_output({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
        check_output({tag, "_pc"}, bus.inst_pc, pc);
        check_output({tag, "_inst"}, bus.inst, data_of(pc));
        check_output({tag, "_fault"}, 32'(bus.inst_fault), 32'(fault));
    endtask

    task automatic pop_entry(input string tag, input logic [31:0] pc, input logic fault);
        check_head(tag, pc, fault);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
    endtask

    task automatic ar_handshake(input string tag, input logic [31:0] addr, input logic [7:0] len);
        check_output({tag, "_arvalid"}, 32'(bus.arvalid), 32'd1);
        check_output({tag, "_araddr"}, bus.araddr, addr);
        check_output({tag, "_arlen"}, 32'(bus.arlen), 32'(len));
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
    endtask

    task automatic wait_arvalid();
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.arvalid && waited < 20);
    endtask

    task automatic do_ar(input string tag, input logic [31:0] addr, input logic [7:0] len);
        wait_arvalid();
        ar_handshake(tag, addr, len);
    endtask

    task automatic send_beat(input string tag, input logic [31:0] pc, input logic [1:0] resp,
                             input logic last, input logic pop);
        check_output({tag, "_rready"}, 32'(bus.rready), 32'd1);
        bus.rvalid     = 1'b1;
        bus.rdata      = data_of(pc);
        bus.rresp      = resp;
        bus.rlast      = last;
        bus.inst_ready = pop;
        @(negedge clk);
        bus.rvalid     = 1'b0;
        bus.rlast      = 1'b0;
        bus.rresp      = 2'b00;
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        bus.arready        = 1'b0;
        bus.rvalid         = 1'b0;
        bus.rdata          = '0;
        bus.rresp          = 2'b00;
        bus.rlast          = 1'b0;

        // Reset state
        @(negedge clk);
        check_output("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check_output("rst_rready", 32'(bus.rready), 32'd0);
        check_output("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        rst = 1'b1;

        // First AR on the first edge after reset release, full aligned burst
        @(negedge clk);
        check_output("t1_arid", 32'(bus.arid), 32'd0);
        check_output("t1_arsize", 32'(bus.arsize), 32'd2);
        check_output("t1_arburst", 32'(bus.arburst), 32'd1);
        ar_handshake("t1_ar", 32'h8000_0000, 8'd3);
        for (int i = 0; i < 4; i++)
            send_beat("t1_beat", 32'h8000_0000 + 32'(4 * i), 2'b00, i == 3, 1'b0);

        // Buffer full: no further AR until all four entries leave
        for (int i = 0; i < 2; i++) begin
            check_output("t6_full_no_ar", 32'(bus.arvalid), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            check_output("t6_pop_no_ar", 32'(bus.arvalid), 32'd0);
            pop_entry("t1_pop", 32'h8000_0000 + 32'(4 * i), 1'b0);
        end
        check_output("t6_empty_no_ar_yet", 32'(bus.arvalid), 32'd0);
        check_output("t6_empty", 32'(bus.inst_valid), 32'd0);
        do_ar("t1_next_ar", 32'h8000_0010, 8'd3);

        // Push and pop in the same cycle keep the occupancy right
        send_beat("t6_beat", 32'h8000_0010, 2'b00, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            check_head("t6_head", 32'h8000_0010 + 32'(4 * (i - 1)), 1'b0);
            send_beat("t6_beat", 32'h8000_0010 + 32'(4 * i), 2'b00, i == 3, 1'b1);
        end
        check_head("t6_last_head", 32'h8000_001C, 1'b0);

        // Redirect from IDLE together with an IDU pop: the redirect wins
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0108;
        bus.inst_ready     = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        check_output("t2_flushed", 32'(bus.inst_valid), 32'd0);
        do_ar("t2_ar", 32'h8000_0108, 8'd1);
        send_beat("t2_beat", 32'h8000_0108, 2'b00, 1'b0, 1'b0);
        send_beat("t2_beat", 32'h8000_010C, 2'b00, 1'b1, 1'b0);
        pop_entry("t2_pop", 32'h8000_0108, 1'b0);
        pop_entry("t2_pop", 32'h8000_010C, 1'b0);
        do_ar("t2_next_ar", 32'h8000_0110, 8'd3);

        // Redirect mid-burst after two beats: flush, drain the rest, refetch
        send_beat("t3_beat", 32'h8000_0110, 2'b00, 1'b0, 1'b0);
        send_beat("t3_beat", 32'h8000_0114, 2'b00, 1'b0, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check_output("t3_flushed", 32'(bus.inst_valid), 32'd0);
        send_beat("t3_drain", 32'h8000_0118, 2'b00, 1'b0, 1'b0);
        check_output("t3_drain_no_ar", 32'(bus.arvalid), 32'd0);
        send_beat("t3_drain", 32'h8000_011C, 2'b00, 1'b1, 1'b0);
        check_output("t3_discarded", 32'(bus.inst_valid), 32'd0);
        do_ar("t3_ar", 32'h8000_0200, 8'd3);
        for (int i = 0; i < 4; i++)
            send_beat("t3_beat2", 32'h8000_0200 + 32'(4 * i), 2'b00, i == 3, 1'b0);
        for (int i = 0; i < 4; i++)
            pop_entry("t3_pop", 32'h8000_0200 + 32'(4 * i), 1'b0);

        // Redirect while AR is stalled: address holds, burst is drained, nothing stale appears
        wait_arvalid();
        check_output("t4_araddr_first", bus.araddr, 32'h8000_0210);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0300;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("t4_arvalid_hold", 32'(bus.arvalid), 32'd1);
            check_output("t4_araddr_hold", bus.araddr, 32'h8000_0210);
            @(negedge clk);
        end
        ar_handshake("t4_ar", 32'h8000_0210, 8'd3);
        for (int i = 0; i < 4; i++) begin
            check_output("t4_no_entry", 32'(bus.inst_valid), 32'd0);
            send_beat("t4_drain", 32'h8000_0210 + 32'(4 * i), 2'b00, i == 3, 1'b0);
        end
        check_output("t4_no_entry_end", 32'(bus.inst_valid), 32'd0);
        do_ar("t4_refetch", 32'h8000_0300, 8'd3);

        // Fault on beat 2: entry flagged, beat 3 dropped, fetch halted until a redirect
        send_beat("t5_beat", 32'h8000_0300, 2'b00, 1'b0, 1'b0);
        send_beat("t5_beat", 32'h8000_0304, 2'b00, 1'b0, 1'b0);
        send_beat("t5_beat", 32'h8000_0308, 2'b10, 1'b0, 1'b0);
        send_beat("t5_drain", 32'h8000_030C, 2'b00, 1'b1, 1'b0);
        pop_entry("t5_pop", 32'h8000_0300, 1'b0);
        pop_entry("t5_pop", 32'h8000_0304, 1'b0);
        pop_entry("t5_pop_fault", 32'h8000_0308, 1'b1);
        check_output("t5_beat3_dropped", 32'(bus.inst_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_output("t5_halted", 32'(bus.arvalid), 32'd0);
            @(negedge clk);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0404;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        do_ar("t5_resume", 32'h8000_0404, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
